// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_bus_pkg : shared state type and constants for the WB master  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_BUSY = 2'd1,
    MM_DONE = 2'd2
  } mem_master_state_t;

  localparam logic [31:0] WB_ERROR_DATA = 32'hBAD1_BAD1;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_timeout_counter : counts bus-cycle wait states, flags expiry |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module bus_timeout_counter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd64
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] count_q, count_d;
  logic        expired_q, expired_d;

  // expired is precomputed from the next count so it is high during the
  // cycle in which count_q == TIMEOUT_CYCLES-1, straight from a flop.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 32'd0;
    end else if (enable) begin
      count_d = count_q + 32'd1;
    end
    expired_d = (TIMEOUT_CYCLES != 32'd0) && (count_d == (TIMEOUT_CYCLES - 32'd1));
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      count_q   <= 32'd0;
      expired_q <= (TIMEOUT_CYCLES == 32'd1);
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule
`default_nettype wire

// File: rtl/wb_mem_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_mem_master : single-cycle Wishbone classic master with timeout|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_mem_master
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd64,
  parameter logic [31:0] ERROR_DATA     = WB_ERROR_DATA
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        write_in,
  input  logic        read_in,
  input  logic [31:0] adr_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  sel_in,
  output logic [31:0] data_out,
  output logic        mem_busy,
  output logic        done,
  output logic        error,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i
);

  mem_master_state_t state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] data_out_q, data_out_d;
  logic        error_q, error_d;
  logic        expired;
  logic        busy;

  assign busy = (state_q == MM_BUSY);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .nRst    (nRst),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    data_out_d = data_out_q;
    error_d    = error_q;
    case (state_q)
      MM_IDLE: begin
        if (write_in || read_in) begin
          adr_d   = adr_in;
          dat_d   = data_in;
          sel_d   = sel_in;
          we_d    = write_in;
          error_d = 1'b0;
          state_d = MM_BUSY;
        end
      end
      MM_BUSY: begin
        // err beats ack; ack on the final timeout cycle still succeeds
        if (err_i) begin
          state_d = MM_DONE;
          error_d = 1'b1;
          if (!we_q) data_out_d = ERROR_DATA;
        end else if (ack_i) begin
          state_d = MM_DONE;
          error_d = 1'b0;
          if (!we_q) data_out_d = dat_i;
        end else if (expired) begin
          state_d = MM_DONE;
          error_d = 1'b1;
          if (!we_q) data_out_d = ERROR_DATA;
        end
      end
      MM_DONE: begin
        state_d = MM_IDLE;
      end
      default: begin
        state_d = MM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= MM_IDLE;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      we_q       <= 1'b0;
      data_out_q <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
    end
  end

  assign mem_busy = busy;
  assign cyc_o    = busy;
  assign stb_o    = busy;
  assign we_o     = busy & we_q;
  assign adr_o    = busy ? adr_q : 32'd0;
  assign dat_o    = busy ? dat_q : 32'd0;
  assign sel_o    = busy ? sel_q : 4'd0;
  assign done     = (state_q == MM_DONE);
  assign error    = error_q;
  assign data_out = data_out_q;

endmodule
`default_nettype wire
